// File: rtl/demux_1to8_tdm_pkg.sv
// rtl/demux_1to8_tdm_pkg.sv - shared constants and FSM encoding for the 1-to-8 TDM demux
package demux_1to8_tdm_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/demux_1to8_tdm_if.sv
// rtl/demux_1to8_tdm_if.sv - serial input, lane select and held-lane output bundle
interface demux_1to8_tdm_if;
    import demux_1to8_tdm_pkg::*;

    logic             F;
    logic             F_valid;
    logic             auto_en;
    logic             W0;
    logic             W1;
    logic             W2;
    logic             clear;
    logic [LANES-1:0] S;
    logic [LANES-1:0] S_written;
    logic [SEL_W-1:0] sel_out;
    logic             frame_done;
    logic             busy;

    modport master (
        output F, F_valid, auto_en, W0, W1, W2, clear,
        input  S, S_written, sel_out, frame_done, busy
    );

    modport slave (
        input  F, F_valid, auto_en, W0, W1, W2, clear,
        output S, S_written, sel_out, frame_done, busy
    );

endinterface

// File: rtl/demux_1to8_tdm_sel_decode.sv
// rtl/demux_1to8_tdm_sel_decode.sv - 3-to-8 one-hot lane write-enable decoder
module demux_sel_decode
    import demux_1to8_tdm_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [LANES-1:0] onehot
);

    logic [3:0] group;

    // idx[2:1] (W0,W1) picks a lane pair the way the 4:1 mux stage does; idx[0] picks within it
    always_comb begin
        group  = '0;
        onehot = '0;
        group[idx[2:1]] = en;
        for (int g = 0; g < 4; g++) begin
            onehot[2*g]   = group[g] & ~idx[0];
            onehot[2*g+1] = group[g] &  idx[0];
        end
    end

endmodule

// File: rtl/demux_1to8_tdm.sv
// rtl/demux_1to8_tdm.sv - registered 1-to-8 demux with manual select and counter-driven frame scan
module demux_1to8_tdm
    import demux_1to8_tdm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    demux_1to8_tdm_if.slave bus
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] s_q, s_d;
    logic [LANES-1:0] written_q, written_d;
    logic             frame_done_q;
    logic             busy_q;

    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
    logic             clr_written;
    logic             start_frame;
    logic [LANES-1:0] lane_en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        clr_written = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.auto_en) begin
                    start_frame = 1'b1;
                end else begin
                    wr_idx = {bus.W0, bus.W1, bus.W2};
                    wr_en  = bus.F_valid;
                end
            end
            ST_SCAN: begin
                if (!bus.auto_en) begin
                    // abort: partial lane contents are kept, the pending write is dropped
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.F_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + SEL_W'(1);
                    if (cnt_q == SEL_W'(LANES - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.auto_en) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // a new frame starts at lane 0 and may take its first bit in the same cycle
        if (start_frame) begin
            state_d     = ST_SCAN;
            clr_written = 1'b1;
            wr_idx      = '0;
            wr_en       = bus.F_valid;
            cnt_d       = bus.F_valid ? SEL_W'(1) : '0;
        end

        if (bus.clear) begin
            state_d = bus.auto_en ? ST_SCAN : ST_IDLE;
            cnt_d   = '0;
            wr_en   = 1'b0;
        end
    end

    demux_sel_decode u_sel_decode (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (lane_en)
    );

    always_comb begin
        s_d       = (s_q & ~lane_en) | (lane_en & {LANES{bus.F}});
        written_d = (clr_written ? '0 : written_q) | lane_en;
        if (bus.clear) begin
            s_d       = '0;
            written_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s_q          <= '0;
            written_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_q          <= s_d;
            written_q    <= written_d;
            frame_done_q <= (state_d == ST_DONE);
            busy_q       <= (state_d == ST_SCAN);
        end
    end

    assign bus.S          = s_q;
    assign bus.S_written  = written_q;
    assign bus.sel_out    = cnt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_demux_1to8_tdm.sv
// tb/tb_demux_1to8_tdm.sv - directed and random checks of demux_1to8_tdm against a frame-level model
module tb_demux_1to8_tdm;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    demux_1to8_tdm_if bus ();

    demux_1to8_tdm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: lane arrays, a frame-active flag and a lane position
    bit m_s [8];
    bit m_w [8];
    int m_pos;
    bit m_active;
    bit m_done;
    int m_done_count;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_s[i] = 0;
            m_w[i] = 0;
        end
        m_pos    = 0;
        m_active = 0;
        m_done   = 0;
    endtask

    task automatic model_step(input bit f, input bit fv, input bit ae,
                              input bit [2:0] w, input bit clr);
        bit was_done;
        was_done = m_done;
        m_done   = 0;
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                m_s[i] = 0;
                m_w[i] = 0;
            end
            m_pos    = 0;
            m_active = ae;
            return;
        end
        if (m_active) begin
            if (!ae) begin
                m_active = 0;
                m_pos    = 0;
            end else if (fv) begin
                m_s[m_pos] = f;
                m_w[m_pos] = 1;
                m_pos      = m_pos + 1;
                if (m_pos == 8) begin
                    m_pos    = 0;
                    m_active = 0;
                    m_done   = 1;
                    m_done_count++;
                end
            end
        end else if (ae) begin
            for (int i = 0; i < 8; i++) m_w[i] = 0;
            m_active = 1;
            m_pos    = 0;
            if (fv) begin
                m_s[0] = f;
                m_w[0] = 1;
                m_pos  = 1;
            end
        end else if (!was_done && fv) begin
            m_s[int'(w)] = f;
            m_w[int'(w)] = 1;
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        logic [7:0] es, ew;
        for (int i = 0; i < 8; i++) begin
            es[i] = m_s[i];
            ew[i] = m_w[i];
        end
        check_val({tag, ".S"}, bus.S, es);
        check_val({tag, ".S_written"}, bus.S_written, ew);
        check_val({tag, ".sel_out"}, {5'd0, bus.sel_out}, 8'(m_pos));
        check_val({tag, ".frame_done"}, {7'd0, bus.frame_done}, {7'd0, m_done});
        check_val({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, m_active});
    endtask

    task automatic step(input logic f, input logic fv, input logic ae,
                        input logic [2:0] w, input logic clr, input string tag);
        bus.F       = f;
        bus.F_valid = fv;
        bus.auto_en = ae;
        {bus.W0, bus.W1, bus.W2} = w;
        bus.clear   = clr;
        @(posedge clk);
        model_step(f, fv, ae, w, clr);
        #1;
        check_model(tag);
    endtask

    logic [7:0] pat;
    logic [7:0] mux_data;
    int         seen_done;
    int         exp_done;

    initial begin
        n_pass       = 0;
        n_total      = 0;
        m_done_count = 0;
        bus.F = 0; bus.F_valid = 0; bus.auto_en = 0;
        bus.W0 = 0; bus.W1 = 0; bus.W2 = 0; bus.clear = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // mid-frame asynchronous reset with the counter at 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "pre_reset");
        check_val("pre_reset_cnt", {5'd0, bus.sel_out}, 8'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        check_val("async_reset_S", bus.S, 8'h00);
        bus.auto_en = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // manual write to lane {W0,W1,W2} = 101
        step(1'b1, 1'b1, 1'b0, 3'b101, 1'b0, "manual");
        check_val("manual_S", bus.S, 8'b0010_0000);
        check_val("manual_W", bus.S_written, 8'b0010_0000);
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "manual_hold");

        // auto frame with gaps
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            step(pat[i], 1'b1, 1'b1, 3'd0, 1'b0, "auto");
            if (i != 7 && (i % 2) == 1) step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "auto_gap");
        end
        check_val("auto_S", bus.S, 8'b0100_1101);
        check_val("auto_done", {7'd0, bus.frame_done}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "auto_end");
        check_val("auto_done_off", {7'd0, bus.frame_done}, 8'd0);

        // abort after three writes
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "abort_fill");
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "abort");
        check_val("abort_W", bus.S_written, 8'b0000_0111);
        check_val("abort_sel", {5'd0, bus.sel_out}, 8'd0);
        check_val("abort_done", {7'd0, bus.frame_done}, 8'd0);

        // clear racing the 8th write
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "race_fill");
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, "race");
        check_val("race_S", bus.S, 8'h00);
        check_val("race_done", {7'd0, bus.frame_done}, 8'd0);
        check_val("race_sel", {5'd0, bus.sel_out}, 8'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "race_end");

        // back-to-back frames with continuous valid
        seen_done = 0;
        exp_done  = m_done_count;
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom), 1'b1, 1'b1, 3'd0, 1'b0, "b2b");
            if (bus.frame_done === 1'b1) seen_done++;
        end
        check_val("b2b_pulses", 8'(seen_done), 8'(m_done_count - exp_done));
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "b2b_end");

        // loopback: sel_out selects the mux input that feeds F
        mux_data = 8'($urandom);
        for (int i = 0; i < 8; i++)
            step(mux_data[bus.sel_out], 1'b1, 1'b1, 3'd0, 1'b0, "loop");
        check_val("loop_S", bus.S, mux_data);
        check_val("loop_done", {7'd0, bus.frame_done}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "loop_end");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0),
                 3'($urandom), ($urandom_range(0, 29) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
